// File: rtl/branch_predict_controller.sv
// branch_predict_controller
//
// Shares the branch target buffer's single PC/target port between fetch
// lookups and resolved-branch updates, keeps an optional table of 2-bit
// saturating direction counters, forms the predicted next fetch PC, and
// raises a registered flush/redirect on a direction misprediction.
//
// Configuration macro: BPC_COUNTERS_EN
//   defined   - counter table present, direction = ctr[idx(fetchPC)][1]
//   undefined - no counter storage, predict taken on any valid buffer hit
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fetchPC/Valid     fetch-stage PC and its valid qualifier
//   btbPC             address presented to the buffer (lookup or update)
//   btbTargetIn       target the buffer writes at the next edge
//   btbTargetOut/Hit  buffer's combinational lookup result for btbPC
//   nextPC            PC fetch loads at the next edge
//   predTaken         current fetch predicted taken
//   fetchStall        fetch must hold its PC (port used for an update)
//   resolve*          execute-stage branch resolution
//   flush/redirectPC  registered squash pulse and correct fetch PC

module branch_predict_controller #(
  parameter int unsigned CTR_IDX_BITS = 4,
  parameter logic [1:0]  CTR_INIT     = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetchPC,
  input  logic        fetchValid,
  output logic [31:0] btbPC,
  output logic [31:0] btbTargetIn,
  input  logic [31:0] btbTargetOut,
  input  logic        btbHit,
  output logic [31:0] nextPC,
  output logic        predTaken,
  output logic        fetchStall,
  input  logic        resolveValid,
  input  logic [31:0] resolvePC,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTarget,
  input  logic        resolvePredTaken,
  output logic        flush,
  output logic [31:0] redirectPC
);

  typedef enum logic [0:0] {StLookup, StUpdate} state_e;

  state_e      state_q;
  logic        flush_q;
  logic [31:0] redirect_q;
  logic [31:0] pend_pc_q;
  logic [31:0] pend_tgt_q;

  logic [31:0] fetch_pc_inc;
  logic [31:0] resolve_pc_inc;
  logic        mispredict;
  logic        resolve_taken;
  logic        pred_dir;

  // 32-bit modulo arithmetic: 0xFFFFFFFC + 4 wraps to zero.
  assign fetch_pc_inc   = fetchPC + 32'd4;
  assign resolve_pc_inc = resolvePC + 32'd4;
  assign mispredict     = resolveValid && (resolveTaken != resolvePredTaken);
  assign resolve_taken  = resolveValid && resolveTaken;

`ifdef BPC_COUNTERS_EN
  localparam int unsigned NumCtr = 1 << CTR_IDX_BITS;

  logic [1:0]              ctr_q [NumCtr];
  logic [CTR_IDX_BITS-1:0] fetch_idx;
  logic [CTR_IDX_BITS-1:0] resolve_idx;

  assign fetch_idx   = fetchPC[CTR_IDX_BITS+1:2];
  assign resolve_idx = resolvePC[CTR_IDX_BITS+1:2];

  // Lookups read ctr_q directly, so a same-cycle resolve to the same index
  // is only seen from the following cycle on.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumCtr; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (resolveValid) begin
      if (resolveTaken) begin
        if (ctr_q[resolve_idx] != 2'b11) begin
          ctr_q[resolve_idx] <= ctr_q[resolve_idx] + 2'b01;
        end
      end else begin
        if (ctr_q[resolve_idx] != 2'b00) begin
          ctr_q[resolve_idx] <= ctr_q[resolve_idx] - 2'b01;
        end
      end
    end
  end

  assign pred_dir = ctr_q[fetch_idx][1];
`else
  // Without the table every buffer hit is predicted taken.
  logic unused_ctr_cfg;
  assign unused_ctr_cfg = ^{CTR_INIT, CTR_IDX_BITS};
  assign pred_dir       = 1'b1;
`endif

  // Port sequencing, pending update and registered flush/redirect.
  // A taken resolve always (re)loads the pending entry, so consecutive taken
  // resolves keep the FSM in StUpdate writing the newest one each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLookup;
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      pend_pc_q  <= 32'd0;
      pend_tgt_q <= 32'd0;
    end else begin
      flush_q <= mispredict;
      if (mispredict) begin
        redirect_q <= resolveTaken ? resolveTarget : resolve_pc_inc;
      end
      if (resolve_taken) begin
        pend_pc_q  <= resolvePC;
        pend_tgt_q <= resolveTarget;
        state_q    <= StUpdate;
      end else begin
        state_q    <= StLookup;
      end
    end
  end

  always_comb begin
    btbPC       = fetchPC;
    btbTargetIn = fetch_pc_inc;
    predTaken   = 1'b0;
    nextPC      = fetch_pc_inc;
    fetchStall  = 1'b0;
    unique case (state_q)
      StLookup: begin
        btbPC = fetchPC;
        // A hit refreshes the existing entry; a miss inserts the fall-through.
        btbTargetIn = btbHit ? btbTargetOut : fetch_pc_inc;
        predTaken   = fetchValid && btbHit && pred_dir;
        nextPC      = predTaken ? btbTargetOut : fetch_pc_inc;
        fetchStall  = 1'b0;
      end
      StUpdate: begin
        btbPC       = pend_pc_q;
        btbTargetIn = pend_tgt_q;
        predTaken   = 1'b0;
        nextPC      = fetchPC;
        fetchStall  = 1'b1;
      end
      default: ;
    endcase
    // A pending flush wins over any prediction in either state.
    if (flush_q) begin
      nextPC    = redirect_q;
      predTaken = 1'b0;
    end
  end

  assign flush      = flush_q;
  assign redirectPC = redirect_q;

endmodule

// File: tb/tb_branch_predict_controller.sv
module tb_branch_predict_controller;

`ifdef BPC_COUNTERS_EN
  localparam bit CtrEn = 1'b1;
`else
  localparam bit CtrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetchPC;
  logic        fetchValid;
  logic [31:0] btbPC;
  logic [31:0] btbTargetIn;
  logic [31:0] btbTargetOut;
  logic        btbHit;
  logic [31:0] nextPC;
  logic        predTaken;
  logic        fetchStall;
  logic        resolveValid;
  logic [31:0] resolvePC;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic        resolvePredTaken;
  logic        flush;
  logic [31:0] redirectPC;

  branch_predict_controller #(
    .CTR_IDX_BITS(4),
    .CTR_INIT    (2'b01)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetchPC         (fetchPC),
    .fetchValid      (fetchValid),
    .btbPC           (btbPC),
    .btbTargetIn     (btbTargetIn),
    .btbTargetOut    (btbTargetOut),
    .btbHit          (btbHit),
    .nextPC          (nextPC),
    .predTaken       (predTaken),
    .fetchStall      (fetchStall),
    .resolveValid    (resolveValid),
    .resolvePC       (resolvePC),
    .resolveTaken    (resolveTaken),
    .resolveTarget   (resolveTarget),
    .resolvePredTaken(resolvePredTaken),
    .flush           (flush),
    .redirectPC      (redirectPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] next_pc;
    logic        pred;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] btb_pc;
    logic [31:0] btb_tin;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc_cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                 e.name, e.cyc, cyc_cnt);
      end else if (nextPC !== e.next_pc || predTaken !== e.pred || fetchStall !== e.stall ||
                   flush !== e.flush || btbPC !== e.btb_pc || btbTargetIn !== e.btb_tin ||
                   (e.flush && redirectPC !== e.redirect)) begin
        errors++;
        $display({"FAIL %s: got next=%h pred=%b stall=%b flush=%b redir=%h btbPC=%h tin=%h",
                  " want next=%h pred=%b stall=%b flush=%b redir=%h btbPC=%h tin=%h"},
                 e.name, nextPC, predTaken, fetchStall, flush, redirectPC, btbPC, btbTargetIn,
                 e.next_pc, e.pred, e.stall, e.flush, e.redirect, e.btb_pc, e.btb_tin);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc, input logic hit,
                           input logic [31:0] tout);
    fetchValid   = v;
    fetchPC      = pc;
    btbHit       = hit;
    btbTargetOut = tout;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk);
    resolveValid     = v;
    resolvePC        = pc;
    resolveTaken     = tk;
    resolveTarget    = tgt;
    resolvePredTaken = ptk;
  endtask

  task automatic expect_out(input string name, input logic [31:0] nxt, input logic pred,
                            input logic stall, input logic fl, input logic [31:0] redir,
                            input logic [31:0] bpc, input logic [31:0] btin);
    exp_t x;
    x.name     = name;
    x.cyc      = cyc_cnt;
    x.next_pc  = nxt;
    x.pred     = pred;
    x.stall    = stall;
    x.flush    = fl;
    x.redirect = redir;
    x.btb_pc   = bpc;
    x.btb_tin  = btin;
    exp_q.push_back(x);
  endtask

  initial begin
    reset = 1'b1;
    set_fetch(1'b1, 32'h100, 1'b0, 32'h0);
    set_res(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    step();

    step(); reset = 1'b0;
    expect_out("reset", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);

    // Mispredicted taken resolve: flush + one update cycle.
    step(); set_res(1, 32'h200, 1, 32'h400, 0);
    expect_out("res_taken_issue", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("upd_flush", 32'h400, 0, 1, 1, 32'h400, 32'h200, 32'h400);
    step();
    expect_out("post_upd", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);

    // Two more correctly predicted taken resolves, back to back.
    step(); set_res(1, 32'h200, 1, 32'h400, 1);
    expect_out("res_taken2", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);
    step();
    expect_out("upd_b2b_a", 32'h100, 0, 1, 0, 0, 32'h200, 32'h400);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("upd_b2b_b", 32'h100, 0, 1, 0, 0, 32'h200, 32'h400);

    step(); set_fetch(1, 32'h200, 1, 32'h400);
    expect_out("pred_taken", 32'h400, 1, 0, 0, 0, 32'h200, 32'h400);

    // Three mispredicted not-taken resolves.
    step(); set_res(1, 32'h200, 0, 32'h0, 1);
    expect_out("nt_issue", 32'h400, 1, 0, 0, 0, 32'h200, 32'h400);
    step();
    expect_out("nt_flush1", 32'h204, 0, 0, 1, 32'h204, 32'h200, 32'h400);
    step();
    expect_out("nt_flush2", 32'h204, 0, 0, 1, 32'h204, 32'h200, 32'h400);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("nt_flush3", 32'h204, 0, 0, 1, 32'h204, 32'h200, 32'h400);

    step();
    expect_out("sat_zero_a", CtrEn ? 32'h204 : 32'h400, !CtrEn, 0, 0, 0, 32'h200, 32'h400);
    step(); set_res(1, 32'h200, 0, 32'h0, 0);
    expect_out("sat_zero_b", CtrEn ? 32'h204 : 32'h400, !CtrEn, 0, 0, 0, 32'h200, 32'h400);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("sat_zero_c", CtrEn ? 32'h204 : 32'h400, !CtrEn, 0, 0, 0, 32'h200, 32'h400);

    // Consecutive taken resolves: two update cycles, newest written second.
    step(); set_fetch(1, 32'h100, 0, 32'h0); set_res(1, 32'h300, 1, 32'h500, 1);
    expect_out("cons_issue", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);
    step(); set_res(1, 32'h310, 1, 32'h600, 1);
    expect_out("cons_upd1", 32'h100, 0, 1, 0, 0, 32'h300, 32'h500);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("cons_upd2", 32'h100, 0, 1, 0, 0, 32'h310, 32'h600);
    step();
    expect_out("cons_done", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);

    // Same pair with reset on the second resolve: 0x310 is never written.
    step(); set_res(1, 32'h300, 1, 32'h500, 1);
    expect_out("rst_issue", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);
    step(); set_res(1, 32'h310, 1, 32'h600, 1); reset = 1'b1;
    expect_out("rst_upd", 32'h100, 0, 1, 0, 0, 32'h300, 32'h500);
    step(); set_res(0, 32'h0, 0, 32'h0, 0); reset = 1'b0;
    expect_out("rst_abandon", 32'h104, 0, 0, 0, 0, 32'h100, 32'h104);

    // Counter at index 4 went to 2 before reset; reset restores it to 1.
    step(); set_fetch(1, 32'h310, 1, 32'h600);
    expect_out("ctr_reset", CtrEn ? 32'h314 : 32'h600, !CtrEn, 0, 0, 0, 32'h310, 32'h600);

    step(); set_fetch(1, 32'hFFFF_FFFC, 0, 32'h0);
    expect_out("wrap", 32'h0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);

    step(); set_fetch(0, 32'h200, 1, 32'h400);
    expect_out("no_valid", 32'h204, 0, 0, 0, 0, 32'h200, 32'h400);

    // Same-cycle resolve and lookup: lookup sees the old counter (1).
    step(); set_fetch(1, 32'h310, 1, 32'h600); set_res(1, 32'h310, 1, 32'h700, 1);
    expect_out("same_cycle", CtrEn ? 32'h314 : 32'h600, !CtrEn, 0, 0, 0, 32'h310, 32'h600);
    step(); set_res(0, 32'h0, 0, 32'h0, 0);
    expect_out("same_upd", 32'h310, 0, 1, 0, 0, 32'h310, 32'h700);
    step();
    expect_out("ctr_visible", 32'h600, 1, 0, 0, 0, 32'h310, 32'h600);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
